ram_sync_fifo: RTL and testbench

// - Parametrised single-clock FIFO built on an inferred simple-dual-port RAM.
// - Successor to the fixed 16x2048 RAM wrapper: it adds pointer management,

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/ram_sync_fifo_sdpram.sv | 33 +++
 rtl/ram_sync_fifo.sv | 116 +++++++++++
 tb/tb_ram_sync_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width, clog2, read-mode constants.
// Imported by the RAM FIFO top and its storage sub-module.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointer carries one extra wrap bit above the RAM index.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_sync_fifo_sdpram.sv
// Inferred simple-dual-port RAM: one write port, one registered read port.
// Ports: clk, rst (read register only), we/waddr/wdata, re/raddr, q.
module ram_sync_fifo_sdpram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/ram_sync_fifo.sv
// Single-clock FIFO on an SDP RAM with flags, fill count and FWFT option.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data/rd_valid, status flags, count.
module ram_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 11,
  parameter int FWFT          = FWFT_OFF,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] AF = AFULL_THRESH[PW-1:0];
  localparam logic [PW-1:0] AE = AEMPTY_THRESH[PW-1:0];

  if (AFULL_THRESH > DEPTH) begin : g_af_chk
    $error("AFULL_THRESH exceeds DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_ae_chk
    $error("AEMPTY_THRESH must be below DEPTH");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n;
  logic [PW-1:0] count_n;
  logic          wr_ok, rd_inc, pop;
  logic          ram_ne, valid_n;

  assign ram_ne = (wr_ptr != rd_ptr);
  assign wr_ok  = wr_en && !full;

  always_comb begin
    pop     = 1'b0;
    rd_inc  = 1'b0;
    valid_n = 1'b0;
    if (FWFT == FWFT_ON) begin
      // Output register is the RAM read register; refill it when
      // it is empty or being popped this cycle.
      pop     = rd_en && rd_valid;
      rd_inc  = ram_ne && (!rd_valid || pop);
      valid_n = rd_inc || (rd_valid && !pop);
    end else begin
      pop     = rd_en && !empty;
      rd_inc  = pop;
      valid_n = pop;
    end
  end

  always_comb begin
    wr_ptr_n = wr_ptr + {{(PW-1){1'b0}}, wr_ok};
    rd_ptr_n = rd_ptr + {{(PW-1){1'b0}}, rd_inc};
    count_n  = count + {{(PW-1){1'b0}}, wr_ok}
                     - {{(PW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      rd_valid     <= valid_n;
      full         <= (wr_ptr_n[PW-1] != rd_ptr_n[PW-1]) &&
                      (wr_ptr_n[PW-2:0] == rd_ptr_n[PW-2:0]);
      empty        <= (FWFT == FWFT_ON) ? !valid_n
                                        : (wr_ptr_n == rd_ptr_n);
      almost_full  <= (count_n >= AF);
      almost_empty <= (count_n <= AE);
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && ((FWFT == FWFT_ON) ? !rd_valid : empty))
        underflow <= 1'b1;
    end
  end

  ram_sync_fifo_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[PW-2:0]),
    .wdata (wr_data),
    .re    (rd_inc),
    .raddr (rd_ptr[PW-2:0]),
    .q     (rd_data)
  );

endmodule

// File: tb/tb_ram_sync_fifo.sv
// Directed bench for ram_sync_fifo: standard and FWFT instances, DEPTH=16.
// Inputs driven and outputs sampled 1 ns after each rising edge.
module tb_ram_sync_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // standard-mode instance
  logic        rst, wr_en, rd_en;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, full, empty, afull, aempty, ovf, unf;
  logic [4:0]  count;

  // FWFT instance
  logic        f_rst, f_wr_en, f_rd_en;
  logic [15:0] f_wr_data, f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_afull, f_aempty;
  logic        f_ovf, f_unf;
  logic [4:0]  f_count;

  ram_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(afull),
    .almost_empty(aempty), .count(count),
    .overflow(ovf), .underflow(unf)
  );

  ram_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] e;

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; wr_data = '0;
    f_rst = 1; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    tick();
    rst = 0; f_rst = 0;

    // reset state
    chk("rst_count",  32'(count), 0);
    chk("rst_empty",  32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_full",   32'(full), 0);
    chk("rst_afull",  32'(afull), 0);
    chk("rst_valid",  32'(rd_valid), 0);
    chk("rst_data",   32'(rd_data), 0);
    chk("rst_ovf",    32'(ovf), 0);
    chk("rst_unf",    32'(unf), 0);

    // fill 1..16
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1; wr_data = 16'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_aempty", 32'(aempty), (i <= 4) ? 1 : 0);
      chk("fill_afull", 32'(afull), (i >= 12) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 16) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
    end
    // 17th write dropped
    wr_data = 16'h00FF;
    tick();
    wr_en = 0;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_full", 32'(full), 1);

    // drain 1..16 back to back
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1;
      tick();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(i));
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_unf0", 32'(unf), 0);
    tick();
    rd_en = 0;
    chk("unf_set", 32'(unf), 1);
    chk("unf_valid", 32'(rd_valid), 0);
    chk("unf_hold", 32'(rd_data), 16);

    // preload 5, then 20 cycles of concurrent write/read
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 16'(16'h0100 + i);
      q.push_back(wr_data);
      tick();
    end
    chk("pre_count", 32'(count), 5);
    for (int j = 0; j < 20; j++) begin
      wr_en = 1; rd_en = 1; wr_data = 16'(16'h0200 + j);
      q.push_back(wr_data);
      tick();
      e = q.pop_front();
      chk("rw_valid", 32'(rd_valid), 1);
      chk("rw_data", 32'(rd_data), 32'(e));
      chk("rw_count", 32'(count), 5);
    end
    rd_en = 0;

    // grow to 7, then reset during a write
    for (int i = 0; i < 2; i++) begin
      wr_data = 16'(16'h0250 + i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 7);
    rst = 1; wr_data = 16'h0EEE;
    tick();
    rst = 0; wr_en = 0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_unf", 32'(unf), 0);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    chk("mid_rst_aempty", 32'(aempty), 1);

    // refill: only new words come out
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1; wr_data = 16'(16'h0300 + i);
      tick();
    end
    wr_en = 0;
    for (int i = 1; i <= 3; i++) begin
      rd_en = 1;
      tick();
      chk("refill_data", 32'(rd_data), 32'(16'h0300 + i));
    end
    rd_en = 0;
    chk("refill_empty", 32'(empty), 1);

    // FWFT: 2-cycle first-word latency
    chk("f_rst_empty", 32'(f_empty), 1);
    f_wr_en = 1; f_wr_data = 16'hABCD;
    tick();
    f_wr_en = 0;
    chk("f_lat1_valid", 32'(f_rd_valid), 0);
    tick();
    chk("f_lat2_valid", 32'(f_rd_valid), 1);
    chk("f_lat2_data", 32'(f_rd_data), 32'h0000ABCD);
    chk("f_lat2_count", 32'(f_count), 1);
    chk("f_lat2_empty", 32'(f_empty), 0);

    for (int i = 1; i <= 3; i++) begin
      f_wr_en = 1; f_wr_data = 16'(i);
      tick();
    end
    f_wr_en = 0;
    tick();
    chk("f_head_hold", 32'(f_rd_data), 32'h0000ABCD);
    chk("f_count4", 32'(f_count), 4);

    // back-to-back pops: a new word each cycle
    f_rd_en = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("f_pop_valid", 32'(f_rd_valid), 1);
      chk("f_pop_data", 32'(f_rd_data), 32'(i));
    end
    tick();
    chk("f_last_valid", 32'(f_rd_valid), 0);
    chk("f_last_empty", 32'(f_empty), 1);
    chk("f_last_count", 32'(f_count), 0);
    chk("f_unf0", 32'(f_unf), 0);
    tick();
    f_rd_en = 0;
    chk("f_unf_set", 32'(f_unf), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
